perceptron_trainer: RTL and testbench

PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

---
 rtl/fixed_point_pkg.sv | 32 +++
 rtl/perceptron_trainer_pkg.sv | 19 +
 rtl/trainer_sample_mem.sv | 47 ++++
 rtl/perceptron_trainer.sv | 145 ++++++++++++++
 tb/tb_perceptron_trainer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Signed Q8.8 fixed-point type shared by the perceptron datapath and its trainer.
// Results that leave the representable range saturate instead of wrapping.
package FixedPoint;
  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp SFP_ONE = 16'sh0100;

  function automatic sfp sfp_sat(input logic signed [2*SFP_W-1:0] v);
    if (v > 32'sd32767)
      return 16'sh7fff;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[SFP_W-1:0];
  endfunction

  function automatic sfp sfp_add(input sfp a, input sfp b);
    logic signed [2*SFP_W-1:0] s;
    s = 32'(a) + 32'(b);
    return sfp_sat(s);
  endfunction

  // Round half up on the dropped fraction bits before saturating.
  function automatic sfp sfp_mul(input sfp a, input sfp b);
    logic signed [2*SFP_W-1:0] p;
    p = 32'(a) * 32'(b);
    return sfp_sat((p + 32'sd128) >>> SFP_FRAC);
  endfunction
endpackage

// File: rtl/perceptron_trainer_pkg.sv
// Trainer sequencing states and the counter-width helpers derived from memory depth.
package TrainerPkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_TRAIN,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Sample counts run 0..MAX_SAMPLES inclusive, hence the +1.
  function automatic int sample_w(input int max_samples);
    return $clog2(max_samples + 1);
  endfunction

  function automatic int index_w(input int max_samples);
    return (max_samples > 1) ? $clog2(max_samples) : 1;
  endfunction
endpackage

// File: rtl/trainer_sample_mem.sv
// Training-set storage: one synchronous write port, one asynchronous read port.
// Out-of-range addresses are dropped on write and read back as zero.
module trainer_sample_mem
  import FixedPoint::*;
  import TrainerPkg::*;
#(
  parameter int INPUT_UNITS = 2,
  parameter int MAX_SAMPLES = 16,
  parameter int AW          = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  sfp            wr_values [INPUT_UNITS],
  input  sfp            wr_expected,
  input  logic [AW-1:0] rd_addr,
  output sfp            rd_values [INPUT_UNITS],
  output sfp            rd_expected
);
  localparam int IW = index_w(MAX_SAMPLES);

  sfp            mem_values   [MAX_SAMPLES][INPUT_UNITS];
  sfp            mem_expected [MAX_SAMPLES];
  logic          wr_ok, rd_ok;
  logic [IW-1:0] wr_idx, rd_idx;

  assign wr_ok  = wr_en && (32'(wr_addr) < MAX_SAMPLES);
  assign rd_ok  = 32'(rd_addr) < MAX_SAMPLES;
  assign wr_idx = wr_addr[IW-1:0];
  assign rd_idx = rd_addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_values[wr_idx]   <= wr_values;
      mem_expected[wr_idx] <= wr_expected;
    end
  end

  always_comb begin
    rd_expected = '0;
    for (int i = 0; i < INPUT_UNITS; i++) rd_values[i] = '0;
    if (rd_ok) begin
      rd_expected = mem_expected[rd_idx];
      rd_values   = mem_values[rd_idx];
    end
  end
endmodule

// File: rtl/perceptron_trainer.sv
// Sequences epochs of perceptron training over the stored samples until an
// error-free epoch (converged) or the epoch limit is reached.
module perceptron_trainer
  import FixedPoint::*;
  import TrainerPkg::*;
#(
  parameter int INPUT_UNITS = 2,
  parameter int MAX_SAMPLES = 16,
  parameter int EW          = 8,
  localparam int SW         = sample_w(MAX_SAMPLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] num_samples,
  input  logic [EW-1:0] max_epochs,
  input  sfp            learning_rate,
  input  logic          load_en,
  input  logic [SW-1:0] load_addr,
  input  sfp            load_values [INPUT_UNITS],
  input  sfp            load_expected,
  output logic          p_rst,
  output logic          p_training,
  output sfp            p_values [INPUT_UNITS],
  output sfp            p_expected,
  output sfp            p_learning_rate,
  input  sfp            p_prediction,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [EW-1:0] epoch_count,
  output logic [SW-1:0] error_count
);
  localparam logic [SW-1:0] S_ONE = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] E_ONE = {{(EW-1){1'b0}}, 1'b1};

  state_t        state, state_nx;
  logic [SW-1:0] idx, num_lat, err_cnt;
  logic [EW-1:0] max_lat, epoch_cnt, epoch_inc;
  sfp            rate_lat;
  logic          done_r, conv_r;
  logic          run_active, last_sample, mismatch, zero_run;

  trainer_sample_mem #(
    .INPUT_UNITS (INPUT_UNITS),
    .MAX_SAMPLES (MAX_SAMPLES),
    .AW          (SW)
  ) u_mem (
    .clk         (clk),
    .wr_en       (load_en && !run_active),
    .wr_addr     (load_addr),
    .wr_values   (load_values),
    .wr_expected (load_expected),
    .rd_addr     (idx),
    .rd_values   (p_values),
    .rd_expected (p_expected)
  );

  assign epoch_inc   = epoch_cnt + E_ONE;
  assign last_sample = (idx == num_lat - S_ONE);
  assign mismatch    = (p_prediction != p_expected);
  assign zero_run    = (num_samples == '0) || (max_epochs == '0);

  always_comb begin
    state_nx   = state;
    run_active = 1'b0;
    p_rst      = rst;
    p_training = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = zero_run ? ST_DONE : ST_CLEAR;
      ST_CLEAR: begin
        run_active = 1'b1;
        p_rst      = 1'b1;
        state_nx   = ST_TRAIN;
      end
      ST_TRAIN: begin
        run_active = 1'b1;
        p_training = !rst;
        if (last_sample) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        run_active = 1'b1;
        state_nx   = (err_cnt == '0 || epoch_inc == max_lat) ? ST_DONE : ST_TRAIN;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      num_lat   <= '0;
      max_lat   <= '0;
      err_cnt   <= '0;
      epoch_cnt <= '0;
      done_r    <= 1'b0;
      conv_r    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (start) begin
          num_lat   <= num_samples;
          max_lat   <= max_epochs;
          err_cnt   <= '0;
          epoch_cnt <= '0;
          conv_r    <= 1'b0;
          done_r    <= zero_run;
        end
        ST_CLEAR: idx <= '0;
        ST_TRAIN: begin
          // Compares against the prediction made before this edge's weight update.
          if (mismatch) err_cnt <= err_cnt + S_ONE;
          idx <= idx + S_ONE;
        end
        ST_CHECK: begin
          epoch_cnt <= epoch_inc;
          if (err_cnt == '0) begin
            done_r <= 1'b1;
            conv_r <= 1'b1;
          end else if (epoch_inc == max_lat) begin
            done_r <= 1'b1;
          end else begin
            idx     <= '0;
            err_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Rate is pure data: captured on start, never reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) rate_lat <= learning_rate;
  end

  assign busy            = run_active && !rst;
  assign done            = done_r;
  assign converged       = conv_r;
  assign epoch_count     = epoch_cnt;
  assign error_count     = err_cnt;
  assign p_learning_rate = rate_lat;
endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: a behavioural perceptron answers the DUT, and an
// epoch-level integer model predicts each run's outcome.
module tb_perceptron_trainer;
  import FixedPoint::*;

  localparam int IU = 2;
  localparam int MS = 16;
  localparam int EW = 8;
  localparam int SW = $clog2(MS + 1);

  logic          clk = 1'b0;
  logic          rst, start, load_en;
  logic [SW-1:0] num_samples, load_addr, error_count;
  logic [EW-1:0] max_epochs, epoch_count;
  sfp            learning_rate, load_expected;
  sfp            load_values [IU];
  logic          p_rst, p_training, busy, done, converged;
  sfp            p_values [IU];
  sfp            p_expected, p_learning_rate, p_prediction, stub_d;

  int checks = 0;
  int failures = 0;
  int tr_cnt = 0;
  int w_stub [IU];
  int b_stub;
  int net_c;
  int ref_x [MS][IU];
  int ref_t [MS];

  always #5 clk = ~clk;

  perceptron_trainer #(.INPUT_UNITS(IU), .MAX_SAMPLES(MS), .EW(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .max_epochs(max_epochs), .learning_rate(learning_rate), .load_en(load_en),
    .load_addr(load_addr), .load_values(load_values), .load_expected(load_expected),
    .p_rst(p_rst), .p_training(p_training), .p_values(p_values),
    .p_expected(p_expected), .p_learning_rate(p_learning_rate),
    .p_prediction(p_prediction), .busy(busy), .done(done), .converged(converged),
    .epoch_count(epoch_count), .error_count(error_count)
  );

  // Behavioural perceptron: step output, weights kept wide so they never wrap.
  always_comb begin
    net_c = b_stub;
    for (int i = 0; i < IU; i++) net_c = net_c + ((w_stub[i] * int'(p_values[i])) >>> SFP_FRAC);
    p_prediction = (net_c > 0) ? SFP_ONE : '0;
  end

  assign stub_d = sfp_mul(p_learning_rate, sfp_add(p_expected, -p_prediction));

  always @(posedge clk) begin
    if (p_rst) begin
      for (int i = 0; i < IU; i++) w_stub[i] <= 0;
      b_stub <= 0;
    end else if (p_training) begin
      for (int i = 0; i < IU; i++) w_stub[i] <= w_stub[i] + int'(sfp_mul(stub_d, p_values[i]));
      b_stub <= b_stub + int'(stub_d);
    end
    if (p_training) tr_cnt <= tr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plain perceptron learning over whole epochs, in integer units.
  function automatic void ref_run(input int n, input int maxe, input int lr,
                                  output int e, output int conv, output int errs);
    int w [IU];
    int b, net, pred, d;
    e = 0; conv = 0; errs = 0;
    if (n == 0 || maxe == 0) return;
    for (int i = 0; i < IU; i++) w[i] = 0;
    b = 0;
    for (int ep = 1; ep <= maxe; ep++) begin
      errs = 0;
      for (int s = 0; s < n; s++) begin
        net = b;
        for (int i = 0; i < IU; i++) net += w[i] * ref_x[s][i];
        pred = (net > 0) ? 1 : 0;
        if (pred != ref_t[s]) begin
          errs++;
          d = lr * (ref_t[s] - pred);
          for (int i = 0; i < IU; i++) w[i] += d * ref_x[s][i];
          b += d;
        end
      end
      e = ep;
      if (errs == 0) begin
        conv = 1;
        return;
      end
    end
  endfunction

  task automatic load_sample(input int addr, input int x0, input int x1, input int t);
    load_en        = 1'b1;
    load_addr      = addr[SW-1:0];
    load_values[0] = sfp'(x0 * 256);
    load_values[1] = sfp'(x1 * 256);
    load_expected  = sfp'(t * 256);
    tick();
    load_en = 1'b0;
    if (addr < MS) begin
      ref_x[addr][0] = x0;
      ref_x[addr][1] = x1;
      ref_t[addr]    = t;
    end
  endtask

  task automatic run(input string tag, input int n, input int maxe, input int lr, input int disturb_at);
    int cyc, e, conv, errs, tr0, exp_cyc;
    ref_run(n, maxe, lr, e, conv, errs);
    exp_cyc       = (n == 0 || maxe == 0) ? 0 : 1 + e * (n + 1);
    num_samples   = n[SW-1:0];
    max_epochs    = maxe[EW-1:0];
    learning_rate = sfp'(lr * 256);
    start         = 1'b1;
    tick();
    start = 1'b0;
    tr0   = tr_cnt;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      if (cyc == disturb_at) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        start          = 1'b1;
        num_samples    = 2;
        load_en        = 1'b1;
        load_addr      = '0;
        load_values[0] = sfp'(99 * 256);
        load_values[1] = sfp'(-99 * 256);
        load_expected  = sfp'(77 * 256);
      end
      tick();
      start   = 1'b0;
      load_en = 1'b0;
      cyc++;
    end
    check({tag, "_done"},      32'(done),        32'd1);
    check({tag, "_converged"}, 32'(converged),   32'(conv));
    check({tag, "_epochs"},    32'(epoch_count), 32'(e));
    check({tag, "_errors"},    32'(error_count), 32'(errs));
    check({tag, "_cycles"},    32'(cyc),         32'(exp_cyc));
    check({tag, "_train_cyc"}, 32'(tr_cnt - tr0), 32'(e * n));
    tick();
    check({tag, "_done_held"}, 32'(done),        32'd1);
    check({tag, "_idle_busy"}, 32'(busy),        32'd0);
    check({tag, "_ep_held"},   32'(epoch_count), 32'(e));
  endtask

  task automatic load_and();
    load_sample(0, 0, 0, 0);
    load_sample(1, 0, 1, 0);
    load_sample(2, 1, 0, 0);
    load_sample(3, 1, 1, 1);
  endtask

  initial begin
    int n, maxe, lr;
    rst = 1'b1; start = 1'b0; load_en = 1'b0;
    num_samples = '0; max_epochs = '0; learning_rate = '0;
    load_addr = '0; load_expected = '0;
    for (int i = 0; i < IU; i++) load_values[i] = '0;

    tick();
    check("rst_p_rst",      32'(p_rst),      32'd1);
    check("rst_p_training", 32'(p_training), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_done",      32'(done),        32'd0);
    check("rst_converged", 32'(converged),   32'd0);
    check("rst_epochs",    32'(epoch_count), 32'd0);
    check("rst_errors",    32'(error_count), 32'd0);
    check("idle_p_rst",    32'(p_rst),       32'd0);

    load_and();
    // Writes outside the memory must leave sample 0 intact.
    load_values[0] = sfp'(5 * 256); load_values[1] = sfp'(5 * 256);
    load_en = 1'b1; load_addr = SW'(16); load_expected = sfp'(256); tick();
    load_addr = SW'(31); tick();
    load_en = 1'b0;

    run("and", 4, 20, 1, -1);
    check("and_conv_flag", 32'(converged), 32'd1);
    check("and_under_limit", 32'(epoch_count < 20), 32'd1);

    load_sample(0, 0, 0, 0);
    load_sample(1, 0, 1, 1);
    load_sample(2, 1, 0, 1);
    load_sample(3, 1, 1, 0);
    run("xor", 4, 10, 1, -1);
    check("xor_epochs_10", 32'(epoch_count), 32'd10);

    run("zero_n", 0, 5, 1, -1);
    run("zero_ep", 4, 0, 1, -1);

    load_and();
    run("and_disturbed", 4, 20, 1, 3);
    run("and_after_disturb", 4, 20, 1, -1);

    // Reset in the middle of TRAIN, then rerun from the retained memory.
    num_samples = 4; max_epochs = 20; learning_rate = SFP_ONE; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_in_train", 32'(p_training), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_p_rst",      32'(p_rst),      32'd1);
    check("mid_rst_p_training", 32'(p_training), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_after_busy",     32'(busy),        32'd0);
    check("mid_after_training", 32'(p_training),  32'd0);
    check("mid_after_epochs",   32'(epoch_count), 32'd0);
    run("and_after_rst", 4, 20, 1, -1);

    for (int r = 0; r < 6; r++) begin
      n    = int'($urandom_range(1, 6));
      maxe = int'($urandom_range(1, 12));
      lr   = int'($urandom_range(1, 2));
      for (int s = 0; s < n; s++)
        load_sample(s, int'($urandom_range(0, 2)) - 1, int'($urandom_range(0, 2)) - 1,
                    int'($urandom_range(0, 1)));
      run($sformatf("rand%0d", r), n, maxe, lr, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
